cntry_car_sensor: RTL

Conditions the country-road vehicle detectors and produces the car-waiting request `X` for the highway/country signal controller. It synchronizes and debounces an entry loop and an exit loop, keeps a saturating count of cars queued at the country road, and asserts `X` while that count is non-zero. It also watches the controller's `cntry` lamp code and flags cars leaving on red.

---
 rtl/cntry_car_sensor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cntry_car_sensor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : cntry_car_sensor_db
// Description : Loop-detector conditioner. Synchronizes the raw loop signal
//               with two flops, debounces the level and flags the single-cycle
//               acceptance of a new high level.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
module cntry_car_sensor_db #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic clear_n,
  input  logic raw,
  output logic rise
);

  localparam logic [1:0] LOW_STABLE  = 2'd0;
  localparam logic [1:0] LOW_CHK     = 2'd1;
  localparam logic [1:0] HIGH_STABLE = 2'd2;
  localparam logic [1:0] HIGH_CHK    = 2'd3;
  localparam logic [3:0] DC_LAST     = 4'(DEBOUNCE - 1);

  logic       meta;
  logic       s;
  logic [1:0] state;
  logic [3:0] dcnt;

  // Two-flop synchronizer for the asynchronous loop input
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= raw;
      s    <= meta;
    end
  end

  // Debounce FSM; the accepted level db is state[1] (HIGH_* states)
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= LOW_STABLE;
      dcnt  <= 4'd0;
    end else begin
      case (state)
        LOW_STABLE: begin
          dcnt <= 4'd0;
          if (s) state <= LOW_CHK;
        end
        LOW_CHK: begin
          if (!s) begin
            state <= LOW_STABLE;
            dcnt  <= 4'd0;
          end else if (dcnt == DC_LAST) begin
            state <= HIGH_STABLE;
            dcnt  <= 4'd0;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        HIGH_STABLE: begin
          dcnt <= 4'd0;
          if (!s) state <= HIGH_CHK;
        end
        default: begin
          if (s) begin
            state <= HIGH_STABLE;
            dcnt  <= 4'd0;
          end else if (dcnt == DC_LAST) begin
            state <= LOW_STABLE;
            dcnt  <= 4'd0;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Event fires on the same edge that accepts the new high level
  assign rise = (state == LOW_CHK) && s && (dcnt == DC_LAST);

endmodule

// ---------------------------------------------------------------------------
// Module      : cntry_car_sensor
// Description : Country-road car sensor. Counts queued cars from debounced
//               entry/exit loops, requests service via X while cars wait,
//               and keeps sticky overflow and red-runner flags.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
module cntry_car_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             loop_in,
  input  logic             loop_out,
  input  logic [1:0]       cntry,
  input  logic             err_clr,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             ovf,
  output logic             red_run
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       RED     = 2'd0;

  logic             arr;
  logic             dep;
  logic [CNT_W-1:0] next_count;
  logic             ovf_set;
  logic             red_set;

  cntry_car_sensor_db #(.DEBOUNCE(DEBOUNCE)) u_db_in (
    .clock   (clock),
    .clear_n (clear_n),
    .raw     (loop_in),
    .rise    (arr)
  );

  cntry_car_sensor_db #(.DEBOUNCE(DEBOUNCE)) u_db_out (
    .clock   (clock),
    .clear_n (clear_n),
    .raw     (loop_out),
    .rise    (dep)
  );

  // Next queue count and flag-set conditions; simultaneous events cancel
  always_comb begin
    next_count = car_count;
    ovf_set    = 1'b0;
    if (arr && !dep) begin
      if (car_count == CNT_MAX) ovf_set = 1'b1;
      else                      next_count = car_count + 1'b1;
    end else if (dep && !arr) begin
      if (car_count != '0) next_count = car_count - 1'b1;
    end
    red_set = dep && (cntry == RED);
  end

  // Count, request and sticky flags; a set condition beats err_clr
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      car_count <= '0;
      X         <= 1'b0;
      ovf       <= 1'b0;
      red_run   <= 1'b0;
    end else begin
      car_count <= next_count;
      X         <= (next_count != '0);
      ovf       <= ovf_set | (ovf & ~err_clr);
      red_run   <= red_set | (red_run & ~err_clr);
    end
  end

endmodule
`default_nettype wire
